seq_div_cla: RTL



---
 rtl/seq_div_cla.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seq_div_cla.sv
// Iterative unsigned restoring divider, one quotient bit per clock via a CLA4-ripple trial subtractor.
// Latency: out_valid WIDTH edges after acceptance (1 edge for a zero divisor when SEQDIV_ZERO_FAST_EN is defined).
// Backpressure: one operation in flight; in_ready low in CALC/DONE, result held in DONE until out_ready.
module seq_div_cla #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int NST = WIDTH / 4 + 1;
    localparam int EXT = 4 * NST;
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] rem;
        logic             dbz;
    } res_t;

    state_t          state;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   r;
    logic [CW-1:0]    cnt;
    res_t             res;

    logic [WIDTH:0]   s;
    logic [WIDTH:0]   t;
    logic [EXT-1:0]   op_a;
    logic [EXT-1:0]   op_b;
    logic [EXT-1:0]   sum_ext;
    logic             no_borrow;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   r_next;
    logic             unused_bits;

    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign s = {r[WIDTH-1:0], q[WIDTH-1]};

    // S + ~D + 1 across zero-extended CLA4 stages; the carry out of bit WIDTH lands in sum bit WIDTH+1
    always_comb begin
        logic c;
        op_a          = '0;
        op_b          = '0;
        sum_ext       = '0;
        op_a[WIDTH:0] = s;
        op_b[WIDTH:0] = ~{1'b0, d};
        c             = 1'b1;
        for (int i = 0; i < NST; i++) begin
            {c, sum_ext[i*4 +: 4]} = cla4(op_a[i*4 +: 4], op_b[i*4 +: 4], c);
        end
    end

    assign t         = sum_ext[WIDTH:0];
    assign no_borrow = sum_ext[WIDTH+1];
    assign q_shift   = {q[WIDTH-2:0], no_borrow};
    assign r_next    = no_borrow ? t : s;

    assign unused_bits = ^{sum_ext[EXT-1:WIDTH+2], r[WIDTH]};

    assign in_ready    = (state == IDLE);
    assign quotient    = res.quo;
    assign remainder   = res.rem;
    assign div_by_zero = res.dbz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            d         <= '0;
            q         <= '0;
            r         <= '0;
            cnt       <= '0;
            res       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d       <= divisor;
                        q       <= dividend;
                        r       <= '0;
                        cnt     <= '0;
                        res.dbz <= (divisor == '0);
`ifdef SEQDIV_ZERO_FAST_EN
                        if (divisor == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            res.quo   <= '1;
                            res.rem   <= dividend;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    q   <= q_shift;
                    r   <= r_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        res.quo   <= q_shift;
                        res.rem   <= r_next[WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
